// File: rtl/program_loader_pkg.sv
// Constants and state encoding shared by the program loader, the instruction RAM and the CPU.
package program_loader_pkg;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;
  localparam int DEPTH  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // States in which a stream byte may be consumed.
  function automatic logic takes_byte(input state_t s);
    return (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_CHK);
  endfunction

  function automatic logic holds_cpu(input state_t s);
    return !((s == S_IDLE) || (s == S_DONE));
  endfunction

endpackage

// File: rtl/program_loader.sv
// Loads a framed byte stream (LEN, hi/lo word pairs, XOR checksum) into the instruction RAM,
// holding the CPU until the image is complete and its checksum verified.
module program_loader
  import program_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [INST_W-1:0] o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_err,
  output logic [ADDR_W:0]   o_word_count,
  output state_t            o_state
);

  state_t              r_state;
  logic                r_byte_ready;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [INST_W-1:0]   r_wr_data;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic                r_load_err;
  logic [ADDR_W:0]     r_word_count;
  logic [ADDR_W:0]     r_len;
  logic [7:0]          r_chk;

  state_t              w_next;
  logic                w_xfer;
  logic                w_len_bad;
  logic                w_chk_ok;
  logic                w_can_start;
  logic [ADDR_W:0]     w_count_inc;
  logic                w_more_words;

  // Handshake: a byte moves on a rising edge where i_byte_valid and o_byte_ready are both
  // high; o_byte_ready is registered from the next state, so it never depends on i_byte_valid.
  assign w_xfer       = i_byte_valid & r_byte_ready;
  assign w_len_bad    = (i_byte_in == 8'd0) || (i_byte_in > 8'(DEPTH));
  assign w_chk_ok     = (r_chk == i_byte_in);
  assign w_can_start  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_count_inc  = r_word_count + (ADDR_W+1)'(1);
  assign w_more_words = (w_count_inc < r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_LEN;
      S_LEN:   if (w_xfer) w_next = w_len_bad ? S_ERR : S_HI;
      S_HI:    if (w_xfer) w_next = S_LO;
      S_LO:    if (w_xfer) w_next = S_WRITE;
      S_WRITE: w_next = w_more_words ? S_HI : S_CHK;
      S_CHK:   if (w_xfer) w_next = w_chk_ok ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_word_count <= '0;
      r_len        <= '0;
      r_chk        <= '0;
    end else begin
      r_state      <= w_next;
      r_byte_ready <= takes_byte(w_next);
      r_cpu_hold   <= holds_cpu(w_next);
      r_wr_en      <= (w_next == S_WRITE);
      r_load_done  <= (r_state == S_CHK) && (w_next == S_DONE);
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start && w_can_start) begin
            r_load_err   <= 1'b0;
            r_word_count <= '0;
            r_chk        <= '0;
            r_wr_addr    <= '0;
          end
        end
        S_LEN: begin
          if (w_xfer) begin
            r_len <= i_byte_in[ADDR_W:0];
            if (w_len_bad) r_load_err <= 1'b1;
          end
        end
        S_HI: begin
          if (w_xfer) begin
            r_wr_data[15:8] <= i_byte_in;
            r_chk           <= r_chk ^ i_byte_in;
          end
        end
        S_LO: begin
          if (w_xfer) begin
            r_wr_data[7:0] <= i_byte_in;
            r_chk          <= r_chk ^ i_byte_in;
          end
        end
        S_WRITE: begin
          // The address after the last legal word wraps to 0; it is never used for a write.
          r_wr_addr    <= r_wr_addr + ADDR_W'(1);
          r_word_count <= w_count_inc;
        end
        S_CHK: begin
          if (w_xfer && !w_chk_ok) r_load_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_load_done;
  assign o_load_err   = r_load_err;
  assign o_word_count = r_word_count;
  assign o_state      = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a frame-level model.
module tb_program_loader;
  import program_loader_pkg::*;

  logic              i_clk;
  logic              i_rst;
  logic              i_start;
  logic [7:0]        i_byte_in;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [INST_W-1:0] o_wr_data;
  logic              o_cpu_hold;
  logic              o_load_done;
  logic              o_load_err;
  logic [ADDR_W:0]   o_word_count;
  state_t            o_state;

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;
  logic [ADDR_W+INST_W-1:0] exp_q[$];
  logic [7:0] frame_q[$];

  program_loader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_byte_in    (i_byte_in),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_cpu_hold   (o_cpu_hold),
    .o_load_done  (o_load_done),
    .o_load_err   (o_load_err),
    .o_word_count (o_word_count),
    .o_state      (o_state)
  );

  // Clock and watchdog
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected (addr, data)
  always @(negedge i_clk) begin
    if (o_load_done) done_seen++;
    if (o_wr_en) begin
      check("byte_ready_during_write", 32'(o_byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      end else begin
        check("wr_addr_data", 32'({o_wr_addr, o_wr_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_values();
    check("rst_byte_ready", 32'(o_byte_ready), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    check("rst_wr_data", 32'(o_wr_data), 32'd0);
    check("rst_cpu_hold", 32'(o_cpu_hold), 32'd0);
    check("rst_load_done", 32'(o_load_done), 32'd0);
    check("rst_load_err", 32'(o_load_err), 32'd0);
    check("rst_word_count", 32'(o_word_count), 32'd0);
    check("rst_state", 32'(o_state), 32'(S_IDLE));
  endtask

  // Driver tasks: called just after a rising edge, return just after a rising edge
  task automatic do_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy, input bit with_start,
                           input bit is_lo);
    bit took;
    int waited;
    if (gappy) begin
      repeat ($urandom_range(0, 3)) begin
        i_byte_valid = 1'b0;
        i_byte_in    = 8'($urandom);
        @(posedge i_clk); #1;
      end
    end
    i_byte_in    = b;
    i_byte_valid = 1'b1;
    i_start      = with_start;
    took   = 1'b0;
    waited = 0;
    while (!took && waited < 64) begin
      @(negedge i_clk);
      took = o_byte_ready;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      waited++;
    end
    i_byte_valid = 1'b0;
    if (!took) check("byte_accept_timeout", 32'(took), 32'd1);
    else if (is_lo) check("wr_en_after_lo", 32'(o_wr_en), 32'd1);
  endtask

  // Reference model: decode frame_q by the framing rules, queue expected writes, drive, check
  task automatic run_frame(input bit gappy, input int start_at);
    int n, nsend, done0;
    bit bad, ok;
    logic [7:0] x;
    n   = int'(frame_q[0]);
    bad = (n == 0) || (n > DEPTH);
    ok  = 1'b0;
    x   = 8'd0;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({ADDR_W'(i), frame_q[1+2*i], frame_q[2+2*i]});
        x = x ^ frame_q[1+2*i] ^ frame_q[2+2*i];
      end
      ok = (x == frame_q[2*n+1]);
    end
    nsend = bad ? 1 : 2 * n + 2;
    done0 = done_seen;
    do_start();
    check("hold_after_start", 32'(o_cpu_hold), 32'd1);
    check("err_cleared_by_start", 32'(o_load_err), 32'd0);
    for (int i = 0; i < nsend; i++) begin
      send_byte(frame_q[i], gappy, i == start_at,
                !bad && i >= 2 && i <= 2 * n && (i % 2 == 0));
    end
    repeat (3) @(posedge i_clk);
    #1;
    check("writes_all_seen", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_seen - done0), ok ? 32'd1 : 32'd0);
    check("load_err", 32'(o_load_err), ok ? 32'd0 : 32'd1);
    check("cpu_hold_end", 32'(o_cpu_hold), ok ? 32'd0 : 32'd1);
    check("word_count", 32'(o_word_count), bad ? 32'd0 : 32'(n));
    check("final_state", 32'(o_state), ok ? 32'(S_DONE) : 32'(S_ERR));
    exp_q.delete();
  endtask

  task automatic make_random_frame();
    int n;
    logic [7:0] b, x;
    n = $urandom_range(1, DEPTH);
    frame_q = {8'(n)};
    x = 8'd0;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x = x ^ b;
    end
    if ($urandom_range(0, 2) == 0) x = x ^ 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_byte_in = 8'd0; i_byte_valid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values();
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Nominal two-word image
    frame_q = {8'h02, 8'h1E, 8'h08, 8'h01, 8'h00, 8'h17};
    run_frame(1'b0, -1);

    // Checksum mismatch, then a start clears the error
    frame_q = {8'h02, 8'h1E, 8'h08, 8'h01, 8'h00, 8'h18};
    run_frame(1'b0, -1);
    do_start();
    check("restart_clears_err", 32'(o_load_err), 32'd0);
    check("restart_word_count", 32'(o_word_count), 32'd0);
    check("restart_state", 32'(o_state), 32'(S_LEN));

    // Illegal lengths
    frame_q = {8'h00};
    run_frame(1'b0, -1);
    frame_q = {8'h11};
    run_frame(1'b0, -1);

    // Full-depth image
    frame_q = {8'(DEPTH)};
    for (int i = 0; i < DEPTH; i++) begin
      frame_q.push_back(8'h00);
      frame_q.push_back(8'(i));
    end
    frame_q.push_back(8'h00 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^
                      8'h08 ^ 8'h09 ^ 8'h0A ^ 8'h0B ^ 8'h0C ^ 8'h0D ^ 8'h0E ^ 8'h0F);
    run_frame(1'b0, -1);

    // Gapped valid with a start pulse mid-frame
    frame_q = {8'h02, 8'h1E, 8'h08, 8'h01, 8'h00, 8'h17};
    run_frame(1'b1, 3);

    // Random images, some with corrupted checksums
    for (int k = 0; k < 8; k++) begin
      make_random_frame();
      run_frame(1'b1, (k % 2 == 0) ? 2 + 2 * int'($urandom_range(0, 1)) : -1);
    end

    // Reset after the high byte of word 1
    exp_q.push_back({ADDR_W'(0), 16'hA55A});
    do_start();
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
    send_byte(8'hC3, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    check_reset_values();
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_word0_only", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    make_random_frame();
    run_frame(1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
